// File: rtl/serial_compare_ctrl.sv
// Serial magnitude comparator: walks both operands one nibble per cycle, MSB first,
// through a single DataCompare4. Optional macro SERIAL_CMP_EARLY_EXIT_EN ends the walk at the first unequal nibble.

module DataCompare4 (
    input  logic [3:0] iData_a,
    input  logic [3:0] iData_b,
    input  logic [2:0] iData,
    output logic [2:0] oData
);
    always_comb begin
        if (iData_a > iData_b)
            oData = 3'b100;
        else if (iData_a < iData_b)
            oData = 3'b010;
        else
            oData = iData;
    end
endmodule

module serial_compare_ctrl #(
    parameter int N_NIB = 4
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iStart,
    input  logic [4*N_NIB-1:0] iData_a,
    input  logic [4*N_NIB-1:0] iData_b,
    output logic               oBusy,
    output logic               oDone,
    output logic [2:0]         oData
);
    localparam logic [2:0] IDX_MSB = 3'(N_NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state;
    logic [2:0]         r_idx;
    logic [4*N_NIB-1:0] r_a;
    logic [4*N_NIB-1:0] r_b;
    logic               r_busy;
    logic               r_done;
    logic [2:0]         r_data;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
    logic [2:0]         r_first;
`endif

    logic [4*N_NIB-1:0] w_a_sh;
    logic [4*N_NIB-1:0] w_b_sh;
    logic [2:0]         w_cmp;

    assign w_a_sh = r_a >> {r_idx, 2'b00};
    assign w_b_sh = r_b >> {r_idx, 2'b00};

    DataCompare4 u_cmp (
        .iData_a (w_a_sh[3:0]),
        .iData_b (w_b_sh[3:0]),
        .iData   (3'b001),
        .oData   (w_cmp)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= IDLE;
            r_idx   <= 3'd0;
            r_a     <= '0;
            r_b     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= 3'b000;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
            r_first <= 3'b001;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (iStart) begin
                        r_a     <= iData_a;
                        r_b     <= iData_b;
                        r_idx   <= IDX_MSB;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
                        r_first <= 3'b001;
`endif
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                    if (w_cmp != 3'b001 || r_idx == 3'd0) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_data  <= w_cmp;
                    end else begin
                        r_idx <= r_idx - 3'd1;
                    end
`else
                    // The most significant unequal nibble decides; later nibbles are don't-care.
                    if (r_first == 3'b001)
                        r_first <= w_cmp;
                    if (r_idx == 3'd0) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_data  <= (r_first == 3'b001) ? w_cmp : r_first;
                    end else begin
                        r_idx <= r_idx - 3'd1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign oBusy = r_busy;
    assign oDone = r_done;
    assign oData = r_data;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl (N_NIB=4): vector table plus restart, back-to-back
// and mid-compare reset sequences. Latency k means oDone is seen just before edge +k.

module tb_serial_compare_ctrl;
    logic        iClk = 1'b0;
    logic        iRst;
    logic        iStart;
    logic [15:0] iData_a;
    logic [15:0] iData_b;
    logic        oBusy;
    logic        oDone;
    logic [2:0]  oData;

    int checks = 0;
    int errors = 0;

    serial_compare_ctrl #(.N_NIB(4)) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iStart  (iStart),
        .iData_a (iData_a),
        .iData_b (iData_b),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oData   (oData)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  exp;
        int          lat_en;
        int          lat_no;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input vec_t v);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        return v.lat_en;
`else
        return v.lat_no;
`endif
    endfunction

    task automatic start_cmp(input logic [15:0] a, input logic [15:0] b);
        @(negedge iClk);
        iStart  = 1'b1;
        iData_a = a;
        iData_b = b;
        @(posedge iClk);
    endtask

    // Call right after an accepting edge. hold keeps iStart high and loads na/nb;
    // pulse_k re-raises iStart with na/nb for one cycle mid-compare.
    task automatic wait_done(input bit hold, input int pulse_k,
                             input logic [15:0] na, input logic [15:0] nb,
                             output int lat, output logic [2:0] data, output bit busy_ok);
        lat = 0;
        data = 3'b000;
        busy_ok = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge iClk);
            if (oBusy && oDone) busy_ok = 1'b0;
            if (!oDone && !oBusy) busy_ok = 1'b0;
            if (k == 1) begin
                if (hold) begin
                    iData_a = na;
                    iData_b = nb;
                end else begin
                    iStart = 1'b0;
                end
            end
            if (pulse_k != 0 && k == pulse_k) begin
                iStart  = 1'b1;
                iData_a = na;
                iData_b = nb;
            end
            if (pulse_k != 0 && k == pulse_k + 1) iStart = 1'b0;
            if (oDone) begin
                lat  = k;
                data = oData;
                break;
            end
        end
    endtask

    initial begin
        int         lat;
        logic [2:0] data;
        bit         bok;

        vecs[0] = '{16'h1234, 16'h1234, 3'b001, 5, 5};
        vecs[1] = '{16'hA000, 16'h5FFF, 3'b100, 2, 5};
        vecs[2] = '{16'h0005, 16'h000A, 3'b010, 5, 5};
        vecs[3] = '{16'hFFFF, 16'hFFFE, 3'b100, 5, 5};
        vecs[4] = '{16'h0100, 16'h0200, 3'b010, 3, 5};
        vecs[5] = '{16'h1F00, 16'h2000, 3'b010, 2, 5};
        vecs[6] = '{16'h0000, 16'h0000, 3'b001, 5, 5};

        iRst = 1'b1;
        iStart = 1'b0;
        iData_a = 16'h0;
        iData_b = 16'h0;
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        chk("rst_busy", 32'(oBusy), 32'd0);
        chk("rst_done", 32'(oDone), 32'd0);
        chk("rst_data", 32'(oData), 32'd0);
        iRst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            start_cmp(vecs[i].a, vecs[i].b);
            wait_done(1'b0, 0, 16'h0, 16'h0, lat, data, bok);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(exp_lat(vecs[i])));
            chk($sformatf("v%0d_data", i), 32'(data), 32'(vecs[i].exp));
            chk($sformatf("v%0d_busy", i), 32'(bok), 32'd1);
            @(negedge iClk);
            chk($sformatf("v%0d_pulse", i), 32'(oDone), 32'd0);
            chk($sformatf("v%0d_hold", i), 32'(oData), 32'(vecs[i].exp));
            chk($sformatf("v%0d_idle", i), 32'(oBusy), 32'd0);
        end

        // Restart pulse while running must be ignored.
        start_cmp(16'h0005, 16'h000A);
        wait_done(1'b0, 2, 16'hFFFF, 16'h0000, lat, data, bok);
        chk("ign_lat", 32'(lat), 32'd5);
        chk("ign_data", 32'(data), 32'b010);
        chk("ign_busy", 32'(bok), 32'd1);

        // iStart held through DONE: second compare follows with no idle cycle.
        start_cmp(16'hA000, 16'h5FFF);
        wait_done(1'b1, 0, 16'h0001, 16'h0002, lat, data, bok);
        chk("b2b1_lat", 32'(lat), 32'(exp_lat(vecs[1])));
        chk("b2b1_data", 32'(data), 32'b100);
        chk("b2b1_busy", 32'(bok), 32'd1);
        wait_done(1'b0, 0, 16'h0, 16'h0, lat, data, bok);
        chk("b2b2_lat", 32'(lat), 32'd5);
        chk("b2b2_data", 32'(data), 32'b010);
        chk("b2b2_busy", 32'(bok), 32'd1);

        // Reset in the middle of a compare.
        start_cmp(16'h1234, 16'h1234);
        @(negedge iClk);
        iStart = 1'b0;
        @(posedge iClk);
        #1 iRst = 1'b1;
        #1;
        chk("arst_busy", 32'(oBusy), 32'd0);
        chk("arst_done", 32'(oDone), 32'd0);
        chk("arst_data", 32'(oData), 32'd0);
        begin
            int seen = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge iClk);
                if (oDone) seen++;
            end
            chk("arst_nodone", 32'(seen), 32'd0);
        end
        iRst = 1'b0;
        iStart = 1'b1;
        iData_a = 16'h0005;
        iData_b = 16'h000A;
        @(posedge iClk);
        wait_done(1'b0, 0, 16'h0, 16'h0, lat, data, bok);
        chk("post_lat", 32'(lat), 32'd5);
        chk("post_data", 32'(data), 32'b010);
        chk("post_busy", 32'(bok), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
